// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and scan-code constants for the PS/2 key decoder.
// Receiver states are one-hot.
package ps2_key_decoder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_DATA   = 4'b0010,
        ST_PARITY = 4'b0100,
        ST_STOP   = 4'b1000
    } rx_state_e;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Odd parity over data plus parity bit.
    function automatic logic parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect,
// start/data/parity/stop FSM and mid-frame idle timeout.
module ps2_key_decoder_frame_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned TMO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam logic [31:0] TMO_LAST = 32'(TMO_CYC - 1);

    logic [2:0]  clk_sync;
    logic [1:0]  data_sync;
    logic        fall;
    logic        din;

    rx_state_e   state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic        par, par_n;
    logic [31:0] tmo_cnt, tmo_cnt_n;

    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign din     = data_sync[1];
    assign rx_byte = shreg;

    // Two-flop synchronisers plus a third clock copy for edge detect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par     <= par_n;
            tmo_cnt <= tmo_cnt_n;
        end
    end

    // Next-state, shift and timeout logic.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_n      = par;
        tmo_cnt_n  = '0;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (state != ST_IDLE && !fall) begin
            tmo_cnt_n = tmo_cnt + 32'd1;
        end
        if (state != ST_IDLE && !fall && tmo_cnt == TMO_LAST) begin
            state_n   = ST_IDLE;
            frame_err = 1'b1;
            tmo_cnt_n = '0;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!din) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                ST_DATA: begin
                    shreg_n   = {din, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_PARITY;
                end
                ST_PARITY: begin
                    par_n   = din;
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    if (din && parity_ok(shreg, par)) byte_valid = 1'b1;
                    else                               frame_err  = 1'b1;
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder producing space/esc pulses and space_held.
// PS2_TYPEMATIC_EN: when defined, auto-repeat makes also pulse.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       space,
    output logic       esc,
    output logic       space_held,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_err;

    logic       brk_pend, brk_pend_n;
    logic       ext_pend, ext_pend_n;
    logic       esc_held, esc_held_n;
    logic       held_n;
    logic       space_n, esc_n;

    ps2_key_decoder_frame_rx #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (rx_err)
    );

    // Prefix tracking and make/break decode of each accepted byte.
    always_comb begin
        brk_pend_n = brk_pend;
        ext_pend_n = ext_pend;
        esc_held_n = esc_held;
        held_n     = space_held;
        space_n    = 1'b0;
        esc_n      = 1'b0;
        if (byte_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_pend_n = 1'b1;
            end else if (rx_byte == SC_BREAK) begin
                brk_pend_n = 1'b1;
            end else if (ext_pend) begin
                ext_pend_n = 1'b0;
                brk_pend_n = 1'b0;
            end else if (brk_pend) begin
                if (rx_byte == SC_SPACE) held_n     = 1'b0;
                if (rx_byte == SC_ESC)   esc_held_n = 1'b0;
                brk_pend_n = 1'b0;
            end else if (rx_byte == SC_SPACE) begin
`ifdef PS2_TYPEMATIC_EN
                space_n = 1'b1;
`else
                space_n = ~space_held;
`endif
                held_n = 1'b1;
            end else if (rx_byte == SC_ESC) begin
`ifdef PS2_TYPEMATIC_EN
                esc_n = 1'b1;
`else
                esc_n = ~esc_held;
`endif
                esc_held_n = 1'b1;
            end
        end
    end

    // Output and flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            space      <= 1'b0;
            esc        <= 1'b0;
            space_held <= 1'b0;
            scancode   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
            esc_held   <= 1'b0;
        end else begin
            space      <= space_n;
            esc        <= esc_n;
            space_held <= held_n;
            code_valid <= byte_valid;
            frame_err  <= rx_err;
            brk_pend   <= brk_pend_n;
            ext_pend   <= ext_pend_n;
            esc_held   <= esc_held_n;
            if (byte_valid) scancode <= rx_byte;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed testbench for ps2_key_decoder.
// Uses a 1 MHz nominal clock so the timeout is 200 cycles.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       space, esc, space_held, code_valid, frame_err;
    logic [7:0] scancode;

    int total = 0;
    int bad = 0;
    int n_space = 0, n_esc = 0, n_cv = 0, n_err = 0, n_both = 0;

    ps2_key_decoder #(
        .CLK_HZ     (1_000_000),
        .TIMEOUT_US (200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .space      (space),
        .esc        (esc),
        .space_held (space_held),
        .scancode   (scancode),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (space === 1'b1) n_space++;
        if (esc === 1'b1) n_esc++;
        if (code_valid === 1'b1) n_cv++;
        if (frame_err === 1'b1) n_err++;
        if (space === 1'b1 && esc === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (8) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        logic p;
        p = ~(^b) ^ flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic frame(input string tag, input logic [7:0] b,
                         input logic flip, input int e_sp, input int e_esc,
                         input int e_cv, input int e_err);
        int s0, e0, c0, r0;
        s0 = n_space; e0 = n_esc; c0 = n_cv; r0 = n_err;
        send_frame(b, flip);
        @(negedge clk);
        chk({tag, ".space"}, n_space - s0, e_sp);
        chk({tag, ".esc"}, n_esc - e0, e_esc);
        chk({tag, ".cv"}, n_cv - c0, e_cv);
        chk({tag, ".err"}, n_err - r0, e_err);
    endtask

    initial begin
        int s0, r0, c0;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst.space", int'(space), 0);
        chk("rst.esc", int'(esc), 0);
        chk("rst.held", int'(space_held), 0);
        chk("rst.code", int'(scancode), 0);
        chk("rst.cv", int'(code_valid), 0);
        chk("rst.err", int'(frame_err), 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);

        frame("mk29", 8'h29, 1'b0, 1, 0, 1, 0);
        chk("mk29.code", int'(scancode), 'h29);
        chk("mk29.held", int'(space_held), 1);

        frame("brkF0", 8'hF0, 1'b0, 0, 0, 1, 0);
        chk("brkF0.held", int'(space_held), 1);
        frame("brk29", 8'h29, 1'b0, 0, 0, 1, 0);
        chk("brk29.held", int'(space_held), 0);
        frame("brkF0b", 8'hF0, 1'b0, 0, 0, 1, 0);
        frame("brk76", 8'h76, 1'b0, 0, 0, 1, 0);

        frame("extE0", 8'hE0, 1'b0, 0, 0, 1, 0);
        frame("ext29", 8'h29, 1'b0, 0, 0, 1, 0);
        chk("ext29.held", int'(space_held), 0);

        frame("par76", 8'h76, 1'b1, 0, 0, 0, 1);
        chk("par76.code", int'(scancode), 'h29);
        frame("good76", 8'h76, 1'b0, 0, 1, 1, 0);
        chk("good76.code", int'(scancode), 'h76);

        s0 = n_space; r0 = n_err; c0 = n_cv;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("tmo.err", n_err - r0, 1);
        chk("tmo.cv", n_cv - c0, 0);
        frame("tmo29", 8'h29, 1'b0, 1, 0, 1, 0);
        chk("tmo29.code", int'(scancode), 'h29);

        frame("relF0", 8'hF0, 1'b0, 0, 0, 1, 0);
        frame("rel76", 8'h76, 1'b0, 0, 0, 1, 0);
        s0 = n_esc;
        for (int k = 0; k < 3; k++) send_frame(8'h76, 1'b0);
        @(negedge clk);
`ifdef PS2_TYPEMATIC_EN
        chk("rep76.esc", n_esc - s0, 3);
`else
        chk("rep76.esc", n_esc - s0, 1);
`endif

        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(posedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mrst.held", int'(space_held), 0);
        chk("mrst.code", int'(scancode), 0);
        rst = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        frame("mrst29", 8'h29, 1'b0, 1, 0, 1, 0);
        chk("mrst29.code", int'(scancode), 'h29);
        chk("mrst29.held", int'(space_held), 1);
        frame("mrst76", 8'h76, 1'b0, 0, 1, 1, 0);

        chk("excl", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
